fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, encoding placed in the IF/ID instruction field when the slot is empty or flushed.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 pc  output  64  current fetch address to instruction memory.
REQ-006 instr_in  input  32  instruction memory read data for pc, valid in the same cycle.
REQ-007 branch_taken  input  1  redirect request from the MEM stage.
REQ-008 branch_target  input  64  redirect address, sampled when branch_taken=1.
REQ-009 ex_memread  input  1  Memread of the instruction currently in ID/EX.
REQ-010 ex_write_reg  input  5  destination register of the instruction currently in ID/EX.
REQ-011 if_id_pc  output  64  PC of the held instruction.
REQ-012 if_id_instr  output  32  held instruction, feeding the decoder and ID/EX.
REQ-013 if_id_valid  output  1  held instruction is real, not a bubble.
REQ-014 stall  output  1  combinational; load-use hazard; ID/EX must capture zeroed control.
REQ-015 flush  output  1  combinational, equals branch_taken; downstream registers squash.
REQ-016 stall_count  output  16  saturating count of stall cycles.
REQ-017 flush_count  output  16  saturating count of flush cycles.

Function
REQ-018 Registered state SHALL be: pc, if_id_pc, if_id_instr, if_id_valid, stall_count and flush_count.
REQ-019 Hazard: stall=1 iff if_id_valid & ex_memread & ex_write_reg!=5'd31 & (ex_write_reg==if_id_instr[9:5] | ex_write_reg==if_id_instr[20:16] | (rt_is_source & ex_write_reg==if_id_instr[4:0])).
REQ-020 rt_is_source SHALL be 1 iff if_id_instr[31:21]==11'h7C0 (STUR) or if_id_instr[31:24]==8'hB4 (CBZ).
REQ-021 Priority per cycle SHALL be flush > stall > normal advance.
REQ-022 Flush (branch_taken=1): pc<=branch_target; if_id_valid<=0; if_id_instr<=NOP_INSTR; if_id_pc<=0; stall SHALL be forced to 0 that cycle.
REQ-023 Stall (stall=1, no flush): pc, if_id_pc, if_id_instr and if_id_valid SHALL hold their values.
REQ-024 Normal: pc<=pc+4 (mod 2^64); if_id_pc<=pc; if_id_instr<=instr_in; if_id_valid<=1.
REQ-025 pc wrap: 64'hFFFF_FFFF_FFFF_FFFC+4 SHALL yield 0, with no error flag.
REQ-026 Latency: an instruction fetched at pc in cycle N SHALL appear on if_id_* after the edge ending cycle N.
REQ-027 A stall lasts exactly one cycle per load; the next edge moves the load to EX/MEM and stall falls unless a new hazard exists.
REQ-028 stall_count SHALL increment on each edge where stall=1 and branch_taken=0, and saturate at 16'hFFFF.
REQ-029 flush_count SHALL increment on each edge where branch_taken=1, and saturate at 16'hFFFF.
REQ-030 Register X31 (XZR) SHALL never cause a stall.

Reset
REQ-031 reset_n=0 SHALL immediately, without a clock, set pc=RESET_PC, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, stall_count=0 and flush_count=0.
REQ-032 With if_id_valid=0 after reset, stall SHALL be 0 regardless of ex_* inputs.
REQ-033 Reset asserted mid-stall or mid-flush SHALL discard the pending redirect and hold state.
REQ-034 The first edge after reset_n rises SHALL perform a normal fetch at RESET_PC.

Verification
REQ-035 Reset release, instr_in=32'h8B020020, three edges -> pc=0x0C, if_id_pc=0x08, if_id_valid=1.
REQ-036 if_id_instr=ADD with Rn=5, ex_memread=1, ex_write_reg=5 -> stall=1; pc and IF/ID hold one edge; stall_count=1; next edge advances.
REQ-037 Same as REQ-036 with ex_write_reg=31 -> stall=0, normal advance.
REQ-038 Stall condition plus branch_taken=1 with branch_target=0x100 in the same cycle -> stall=0, flush=1; pc=0x100, if_id_valid=0, if_id_instr=NOP_INSTR; flush_count=1, stall_count unchanged.
REQ-039 if_id_instr=STUR with Rt=7, ex_memread=1, ex_write_reg=7 -> stall=1; ADD with Rd=7 under the same inputs -> stall=0.
REQ-040 Drive stall_count to 16'hFFFF, then one more stall -> stays 16'hFFFF; assert reset_n low between edges -> all outputs take reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with IF/ID register, load-use hazard stall,
//               branch flush and saturating stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [63:0] pc,
    input  logic [31:0] instr_in,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        ex_memread,
    input  logic [4:0]  ex_write_reg,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        stall,
    output logic        flush,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    logic [63:0] pc_q, pc_d;
    logic [63:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic w_rt_is_source;
    logic w_load_use;

    // Rt is a read operand only for STUR and CBZ; elsewhere [4:0] is a destination.
    assign w_rt_is_source = (if_id_instr_q[31:21] == 11'h7C0) ||
                            (if_id_instr_q[31:24] == 8'hB4);

    assign w_load_use = if_id_valid_q && ex_memread && (ex_write_reg != 5'd31) &&
                        ((ex_write_reg == if_id_instr_q[9:5])  ||
                         (ex_write_reg == if_id_instr_q[20:16]) ||
                         (w_rt_is_source && (ex_write_reg == if_id_instr_q[4:0])));

    assign flush = branch_taken;
    assign stall = w_load_use && !branch_taken;

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;

        if (branch_taken) begin
            pc_d          = branch_target;
            if_id_pc_d    = 64'h0;
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
            if (flush_count_q != C_CNT_MAX) begin
                flush_count_d = flush_count_q + 16'd1;
            end
        end else if (stall) begin
            if (stall_count_q != C_CNT_MAX) begin
                stall_count_d = stall_count_q + 16'd1;
            end
        end else begin
            pc_d          = pc_q + 64'd4;
            if_id_pc_d    = pc_q;
            if_id_instr_d = instr_in;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            stall_count_q <= 16'h0;
            flush_count_q <= 16'h0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] C_NOP   = 32'hD503_201F;
    localparam logic [31:0] C_ADD   = 32'h8B02_0020; // ADD X0,X1,X2
    localparam logic [31:0] C_ADD5  = 32'h8B02_00A0; // ADD X0,X5,X2
    localparam logic [31:0] C_ADDD7 = 32'h8B02_0007; // ADD X7,X0,X2
    localparam logic [31:0] C_STUR7 = 32'hF800_0007; // STUR X7,[X0]
    localparam logic [31:0] C_CBZ7  = 32'hB400_0007; // CBZ X7

    logic        clock = 1'b0;
    logic        reset_n;
    logic [63:0] pc;
    logic [31:0] instr_in;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        ex_memread;
    logic [4:0]  ex_write_reg;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        stall;
    logic        flush;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;
    int exp_scnt;

    fetch_stage #(.RESET_PC(64'h0), .NOP_INSTR(C_NOP)) dut (
        .clock(clock), .reset_n(reset_n), .pc(pc), .instr_in(instr_in),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .ex_memread(ex_memread), .ex_write_reg(ex_write_reg),
        .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
        .stall(stall), .flush(flush), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_pc"},     pc, 64'h0);
        check_val({tag, "_idpc"},   if_id_pc, 64'h0);
        check_val({tag, "_instr"},  {32'h0, if_id_instr}, {32'h0, C_NOP});
        check_val({tag, "_valid"},  {63'h0, if_id_valid}, 64'h0);
        check_val({tag, "_scnt"},   {48'h0, stall_count}, 64'h0);
        check_val({tag, "_fcnt"},   {48'h0, flush_count}, 64'h0);
        check_val({tag, "_stall"},  {63'h0, stall}, 64'h0);
    endtask

    initial begin
        reset_n = 1'b0; instr_in = C_ADD; branch_taken = 1'b0; branch_target = 64'h0;
        ex_memread = 1'b1; ex_write_reg = 5'd0;
        #12;
        check_reset_state("rst");

        // Release between edges, then three normal fetches.
        reset_n = 1'b1; ex_memread = 1'b0;
        step(); step(); step();
        check_val("fill_pc",    pc, 64'h0C);
        check_val("fill_idpc",  if_id_pc, 64'h08);
        check_val("fill_valid", {63'h0, if_id_valid}, 64'h1);
        check_val("fill_instr", {32'h0, if_id_instr}, {32'h0, C_ADD});

        // Load-use on Rn=5.
        instr_in = C_ADD5;
        step();
        ex_memread = 1'b1; ex_write_reg = 5'd5; instr_in = C_ADD;
        #1;
        check_val("lu_stall", {63'h0, stall}, 64'h1);
        step();
        check_val("lu_hold_pc",    pc, 64'h10);
        check_val("lu_hold_idpc",  if_id_pc, 64'h0C);
        check_val("lu_hold_instr", {32'h0, if_id_instr}, {32'h0, C_ADD5});
        check_val("lu_scnt",       {48'h0, stall_count}, 64'h1);
        ex_memread = 1'b0;
        #1;
        check_val("lu_release", {63'h0, stall}, 64'h0);
        step();
        check_val("lu_adv_pc",    pc, 64'h14);
        check_val("lu_adv_instr", {32'h0, if_id_instr}, {32'h0, C_ADD});

        // XZR destination never stalls.
        instr_in = C_ADD5;
        step();
        ex_memread = 1'b1; ex_write_reg = 5'd31; instr_in = C_ADD;
        #1;
        check_val("xzr_stall", {63'h0, stall}, 64'h0);
        step();
        check_val("xzr_pc",    pc, 64'h1C);
        check_val("xzr_instr", {32'h0, if_id_instr}, {32'h0, C_ADD});
        check_val("xzr_scnt",  {48'h0, stall_count}, 64'h1);

        // Stall and flush together: flush wins.
        ex_memread = 1'b0; instr_in = C_ADD5;
        step();
        ex_memread = 1'b1; ex_write_reg = 5'd5; branch_taken = 1'b1; branch_target = 64'h100;
        #1;
        check_val("fl_stall", {63'h0, stall}, 64'h0);
        check_val("fl_flush", {63'h0, flush}, 64'h1);
        step();
        branch_taken = 1'b0; ex_memread = 1'b0;
        check_val("fl_pc",    pc, 64'h100);
        check_val("fl_valid", {63'h0, if_id_valid}, 64'h0);
        check_val("fl_instr", {32'h0, if_id_instr}, {32'h0, C_NOP});
        check_val("fl_idpc",  if_id_pc, 64'h0);
        check_val("fl_fcnt",  {48'h0, flush_count}, 64'h1);
        check_val("fl_scnt",  {48'h0, stall_count}, 64'h1);

        // Rt counts as source only for STUR / CBZ.
        instr_in = C_STUR7;
        step();
        ex_memread = 1'b1; ex_write_reg = 5'd7;
        #1;
        check_val("stur_stall", {63'h0, stall}, 64'h1);
        ex_memread = 1'b0; instr_in = C_ADDD7;
        step();
        check_val("addd7_pc", pc, 64'h108);
        ex_memread = 1'b1;
        #1;
        check_val("addd7_stall", {63'h0, stall}, 64'h0);
        ex_memread = 1'b0; instr_in = C_CBZ7;
        step();
        ex_memread = 1'b1;
        #1;
        check_val("cbz_stall", {63'h0, stall}, 64'h1);
        ex_memread = 1'b0;

        // PC wraps silently.
        branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        branch_taken = 1'b0;
        check_val("wrap_pre", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        check_val("wrap_pc",   pc, 64'h0);
        check_val("wrap_idpc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_val("wrap_fcnt", {48'h0, flush_count}, 64'h2);

        // Saturate stall_count with a persistent hazard.
        instr_in = C_ADD5;
        step();
        exp_scnt = 1;
        ex_memread = 1'b1; ex_write_reg = 5'd5;
        while (exp_scnt < 16'hFFFF) begin
            step();
            exp_scnt++;
        end
        check_val("sat_top", {48'h0, stall_count}, 64'hFFFF);
        step();
        check_val("sat_hold", {48'h0, stall_count}, 64'hFFFF);

        // Asynchronous reset mid-stall, between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("arst");
        #5;
        ex_memread = 1'b0; instr_in = C_ADD;
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check_val("post_pc",    pc, 64'h4);
        check_val("post_idpc",  if_id_pc, 64'h0);
        check_val("post_valid", {63'h0, if_id_valid}, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
